// File: rtl/letter_scroller.sv
// -----------------------------------------------------------------------------
// letter_scroller
//
// Scrolls a six-letter word across six seven-segment digits. The word sits in
// a 12-slot ring (six letters followed by six blank slots); a prescaler divides
// clk down to the scroll rate and each terminal count rotates the visible
// window by one slot.
//
// Parameters
//   TICK_DIV  clk cycles per scroll step (>= 2)
//   BLANK     letter code that darkens a digit
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-high reset
//   letter_in0..letter_in5   word to capture (letter_in0 = leftmost)
//   load                     capture letter_in* and restart from offset 0
//   enable                   1 = scrolling runs, 0 = frozen
//   dir                      0 = scroll left, 1 = scroll right
//   letter_out0..letter_out5 window toward the digit decoders (0 = leftmost)
//   step                     one-cycle pulse after each window shift
// -----------------------------------------------------------------------------
module letter_scroller #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter logic [4:0]  BLANK    = 5'd26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] letter_in0,
    input  logic [4:0] letter_in1,
    input  logic [4:0] letter_in2,
    input  logic [4:0] letter_in3,
    input  logic [4:0] letter_in4,
    input  logic [4:0] letter_in5,
    input  logic       load,
    input  logic       enable,
    input  logic       dir,
    output logic [4:0] letter_out0,
    output logic [4:0] letter_out1,
    output logic [4:0] letter_out2,
    output logic [4:0] letter_out3,
    output logic [4:0] letter_out4,
    output logic [4:0] letter_out5,
    output logic       step
);

    localparam int unsigned    PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  TERM      = PW'(TICK_DIV - 1);
    localparam logic [3:0]     LAST_SLOT = 4'd11;
    localparam logic [4:0]     MAX_LEGAL = 5'd26;

    // Only the six word slots are stored; slots 6..11 are constant BLANK.
    logic [4:0]    word_q [6];
    logic [4:0]    word_d [6];
    logic [3:0]    offset_q, offset_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic          step_q,   step_d;

    logic [4:0]    letter_in [6];
    logic [4:0]    window    [6];

    assign letter_in[0] = letter_in0;
    assign letter_in[1] = letter_in1;
    assign letter_in[2] = letter_in2;
    assign letter_in[3] = letter_in3;
    assign letter_in[4] = letter_in4;
    assign letter_in[5] = letter_in5;

    // Next-state logic. Load wins over a coincident terminal count.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            word_d[k] = word_q[k];
        end
        offset_d = offset_q;
        presc_d  = presc_q;
        step_d   = 1'b0;

        if (load) begin
            for (int k = 0; k < 6; k++) begin
                // Codes 27..31 have no glyph; show them dark.
                word_d[k] = (letter_in[k] > MAX_LEGAL) ? BLANK : letter_in[k];
            end
            offset_d = '0;
            presc_d  = '0;
        end else if (enable) begin
            if (presc_q == TERM) begin
                presc_d = '0;
                step_d  = 1'b1;
                if (dir) begin
                    offset_d = (offset_q == 4'd0) ? LAST_SLOT : offset_q - 4'd1;
                end else begin
                    offset_d = (offset_q == LAST_SLOT) ? 4'd0 : offset_q + 4'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    // NOTE: the word storage is reset as well, because the display must go
    // dark the moment reset is applied, not merely after the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 6; k++) begin
                word_q[k] <= BLANK;
            end
            offset_q <= '0;
            presc_q  <= '0;
            step_q   <= 1'b0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                word_q[k] <= word_d[k];
            end
            offset_q <= offset_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
        end
    end

    // Window: slot (offset + K) mod 12; offset <= 11 and K <= 5, so a single
    // conditional subtract is enough for the modulo.
    always_comb begin
        logic [4:0] idx;
        idx = '0;
        for (int k = 0; k < 6; k++) begin
            idx = {1'b0, offset_q} + 5'(k);
            if (idx >= 5'd12) begin
                idx = idx - 5'd12;
            end
            window[k] = (idx < 5'd6) ? word_q[idx[2:0]] : BLANK;
        end
    end

    assign letter_out0 = window[0];
    assign letter_out1 = window[1];
    assign letter_out2 = window[2];
    assign letter_out3 = window[3];
    assign letter_out4 = window[4];
    assign letter_out5 = window[5];
    assign step        = step_q;

endmodule

// File: tb/tb_letter_scroller.sv
// -----------------------------------------------------------------------------
// tb_letter_scroller
//
// Self-checking bench for letter_scroller with TICK_DIV = 4. Directed scenarios
// (reset, left/right scroll, freeze, load at terminal count, illegal codes,
// mid-scroll reset) are followed by a randomized run; every cycle the DUT is
// compared against a behavioural model of the ring, offset and prescaler.
// -----------------------------------------------------------------------------
module tb_letter_scroller;

    localparam int         TICK = 4;
    localparam logic [4:0] BL   = 5'd26;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       load   = 1'b0;
    logic       enable = 1'b0;
    logic       dir    = 1'b0;
    logic [4:0] li [6];
    logic [4:0] lo [6];
    logic       step;

    int n_asserts = 0;
    int n_fails   = 0;

    // Behavioural model: six stored letters, ring position and divider count.
    logic [4:0] m_word [6];
    int         m_off;
    int         m_presc;
    logic       m_step;

    letter_scroller #(.TICK_DIV(TICK), .BLANK(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .letter_in0 (li[0]),
        .letter_in1 (li[1]),
        .letter_in2 (li[2]),
        .letter_in3 (li[3]),
        .letter_in4 (li[4]),
        .letter_in5 (li[5]),
        .load       (load),
        .enable     (enable),
        .dir        (dir),
        .letter_out0(lo[0]),
        .letter_out1(lo[1]),
        .letter_out2(lo[2]),
        .letter_out3(lo[3]),
        .letter_out4(lo[4]),
        .letter_out5(lo[5]),
        .step       (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] w6(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c, input logic [4:0] d,
                                       input logic [4:0] e, input logic [4:0] f);
        return {a, b, c, d, e, f};
    endfunction

    function automatic logic [29:0] dut_window();
        return {lo[0], lo[1], lo[2], lo[3], lo[4], lo[5]};
    endfunction

    // The ring as the specification describes it: 12 entries, word then blanks.
    function automatic logic [29:0] model_window();
        logic [4:0]  ring [12];
        logic [29:0] r;
        for (int i = 0; i < 12; i++) ring[i] = (i < 6) ? m_word[i] : BL;
        r = '0;
        for (int k = 0; k < 6; k++) r = (r << 5) | 30'(ring[(m_off + k) % 12]);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) m_word[k] = BL;
        m_off   = 0;
        m_presc = 0;
        m_step  = 1'b0;
    endtask

    task automatic model_edge();
        m_step = 1'b0;
        if (load) begin
            for (int k = 0; k < 6; k++) m_word[k] = (li[k] > 5'd26) ? BL : li[k];
            m_off   = 0;
            m_presc = 0;
        end else if (enable) begin
            m_presc++;
            if (m_presc == TICK) begin
                m_presc = 0;
                m_off   = (m_off + (dir ? 11 : 1)) % 12;
                m_step  = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".win"},  32'(dut_window()), 32'(model_window()));
        check({tag, ".step"}, 32'(step),         32'(m_step));
    endtask

    // One rising edge, model update, then sample 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic set_word(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                            input logic [4:0] d, input logic [4:0] e, input logic [4:0] f);
        li[0] = a; li[1] = b; li[2] = c; li[3] = d; li[4] = e; li[5] = f;
    endtask

    initial begin
        int steps;
        set_word(0, 0, 0, 0, 0, 0);
        model_reset();

        // Reset without any clock edge (first rising edge is at t=5).
        #1 reset = 1'b1;
        #1;
        check("R.win",  32'(dut_window()), 32'(w6(BL, BL, BL, BL, BL, BL)));
        check("R.step", 32'(step), 32'd0);
        @(negedge clk) reset = 1'b0;

        // Left scroll through a full revolution.
        @(negedge clk);
        set_word(3, 17, 20, 6, 18, 26);
        load = 1'b1; enable = 1'b1; dir = 1'b0;
        cycle("A.load");
        check("A.word", 32'(dut_window()), 32'(w6(3, 17, 20, 6, 18, 26)));
        @(negedge clk) load = 1'b0;
        repeat (3) cycle("A.cnt");
        cycle("A.step1");
        check("A.step1.pulse", 32'(step), 32'd1);
        check("A.step1.win", 32'(dut_window()), 32'(w6(17, 20, 6, 18, 26, 26)));
        steps = 0;
        repeat (11 * TICK) begin
            cycle("A.scroll");
            if (step === 1'b1) steps++;
        end
        check("A.steps", 32'(steps), 32'd11);
        check("A.wrap.win", 32'(dut_window()), 32'(w6(3, 17, 20, 6, 18, 26)));

        // Right scroll: one step lands on offset 11.
        @(negedge clk) begin load = 1'b1; dir = 1'b1; end
        cycle("B.load");
        @(negedge clk) load = 1'b0;
        repeat (TICK) cycle("B.cnt");
        check("B.pulse", 32'(step), 32'd1);
        check("B.win", 32'(dut_window()), 32'(w6(26, 3, 17, 20, 6, 18)));

        // Freeze mid-count; dir toggles while frozen have no effect.
        @(negedge clk) begin load = 1'b1; dir = 1'b0; end
        cycle("C.load");
        @(negedge clk) load = 1'b0;
        repeat (2) cycle("C.cnt");
        @(negedge clk) begin enable = 1'b0; dir = 1'b1; end
        cycle("C.frz");
        @(negedge clk) dir = 1'b0;
        cycle("C.frz");
        @(negedge clk) enable = 1'b1;
        cycle("C.res1");
        check("C.res1.nostep", 32'(step), 32'd0);
        cycle("C.res2");
        check("C.res2.step", 32'(step), 32'd1);
        check("C.res2.win", 32'(dut_window()), 32'(w6(17, 20, 6, 18, 26, 26)));

        // Load coincides with terminal count: load wins.
        @(negedge clk) load = 1'b1;
        cycle("D.load");
        @(negedge clk) load = 1'b0;
        repeat (TICK - 1) cycle("D.cnt");
        @(negedge clk) begin
            set_word(8, 15, 7, 14, 13, 4);
            load = 1'b1;
        end
        cycle("D.tc");
        check("D.tc.nostep", 32'(step), 32'd0);
        check("D.tc.win", 32'(dut_window()), 32'(w6(8, 15, 7, 14, 13, 4)));
        // Load held: offset and prescaler stay at 0, new word every cycle.
        @(negedge clk) set_word(1, 2, 3, 4, 5, 6);
        repeat (TICK + 1) cycle("D.hold");
        check("D.hold.win", 32'(dut_window()), 32'(w6(1, 2, 3, 4, 5, 6)));

        // Illegal codes, then reset mid-scroll.
        @(negedge clk) set_word(1, 2, 31, 4, 5, 27);
        cycle("E.load");
        check("E.illegal", 32'(lo[2]), 32'(BL));
        check("E.win", 32'(dut_window()), 32'(w6(1, 2, 26, 4, 5, 26)));
        @(negedge clk) load = 1'b0;
        repeat (6) cycle("E.run");
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("E.rst.win",  32'(dut_window()), 32'(w6(BL, BL, BL, BL, BL, BL)));
        check("E.rst.step", 32'(step), 32'd0);
        load = 1'b1;
        cycle("E.rst.load_ignored");
        @(negedge clk) begin reset = 1'b0; load = 1'b0; end
        repeat (6) cycle("E.post");
        check("E.post.win", 32'(dut_window()), 32'(w6(BL, BL, BL, BL, BL, BL)));

        // Randomized traffic, including occasional asynchronous resets.
        repeat (400) begin
            @(negedge clk);
            load   = ($urandom_range(15) == 0);
            enable = ($urandom_range(3) != 0);
            dir    = 1'($urandom_range(1));
            for (int k = 0; k < 6; k++) li[k] = 5'($urandom_range(31));
            if ($urandom_range(63) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                #1;
                check_model("F.rst");
                reset = 1'b0;
            end
            cycle("F");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/letter_scroller.md
LETTER_SCROLLER -- requirements
Module: letter_scroller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning clk cycles per scroll step; legal range 2 or more.
REQ-002 SHALL have parameter BLANK, default 26, meaning the letter code that drives a dark display.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports letter_in0..letter_in5  input  5 each  word to scroll; letter_in0 is the leftmost character.
REQ-006 SHALL have port load  input  1  capture letter_in0..5 as the new word.
REQ-007 SHALL have port enable  input  1  1 = scrolling runs, 0 = scrolling frozen.
REQ-008 SHALL have port dir  input  1  0 = scroll left (offset increments), 1 = scroll right (offset decrements).
REQ-009 SHALL have ports letter_out0..letter_out5  output  5 each  window contents toward the seg7 decoders; letter_out0 is the leftmost display.
REQ-010 SHALL have port step  output  1  one-cycle pulse on each window shift.

Function
REQ-011 SHALL hold a 12-entry ring buffer: slots 0-5 hold the captured word; slots 6-11 always hold BLANK.
REQ-012 SHALL set letter_outK to ring[(offset+K) mod 12] for K = 0..5, where offset is a 4-bit register in the range 0..11.
REQ-013 SHALL derive letter_out0..5 combinationally from registered state, adding no latency beyond the register update.
REQ-014 SHALL, on a clk edge with load=1, write letter_inK into slot K, clear offset to 0, and clear the prescaler to 0; outputs show the new word from that edge.
REQ-015 SHALL store BLANK in place of any letter_in value greater than 26 (27-31 are illegal codes).
REQ-016 SHALL increment the prescaler by 1 each cycle while enable=1 and load=0, and hold it while enable=0.
REQ-017 SHALL, when the prescaler equals TICK_DIV-1 with enable=1 and load=0, wrap the prescaler to 0, shift offset by one position, and assert step for exactly that following cycle.
REQ-018 SHALL, when dir=0, advance offset as 11 -> 0; when dir=1, advance offset as 0 -> 11.
REQ-019 SHALL sample dir only at a step edge; a change of dir between steps causes no other effect.
REQ-020 SHALL give load priority when load and a terminal count coincide: no shift occurs and step stays 0.
REQ-021 SHALL, when enable falls mid-count, retain the prescaler value and resume counting from it when enable returns to 1.
REQ-022 SHALL, when load is held high for several cycles, keep offset and the prescaler at 0 and re-capture the inputs every cycle.
REQ-023 SHALL keep step at 0 except in the single cycle after a shift; step is never high on two consecutive cycles.

Reset
REQ-024 SHALL, while reset=1, immediately (without a clock edge) set all 12 slots to BLANK, offset to 0, the prescaler to 0, and step to 0; all letter_out values read BLANK.
REQ-025 SHALL, on reset asserted mid-scroll, abandon the current word; after release, outputs stay BLANK until the next load.
REQ-026 SHALL ignore load and enable while reset=1.

Verification (bench uses TICK_DIV=4)
REQ-027 SHALL cover: reset pulse -> all outputs 26, step 0, with no clk edge needed.
REQ-028 SHALL cover: load word 3,17,20,6,18,26, enable=1, dir=0 -> step every 4 cycles; after the 1st step the outputs are 17,20,6,18,26,26; after 12 steps the outputs return to 3,17,20,6,18,26.
REQ-029 SHALL cover: same word, dir=1, one step -> outputs 26,3,17,20,6,18 (offset 11).
REQ-030 SHALL cover: enable=0 for 2 cycles after 2 counts -> step occurs exactly 2 enabled cycles after re-enable, not 4.
REQ-031 SHALL cover: load asserted on the terminal-count cycle with word 8,15,7,14,13,4 -> step stays 0, offset 0, outputs 8,15,7,14,13,4.
REQ-032 SHALL cover: load letter_in2=31 -> letter_out2 reads 26; then reset asserted mid-scroll -> outputs 26 immediately.
